// File: rtl/ext_trig_pkg.sv
// ---------------------------------------------------------------------------
// ext_trig_pkg
// Shared definitions for the front-panel trigger conditioner:
//   - one-hot state indices and the state enum built from them
//   - statistics counter width and saturation value
//   - sat_inc(): saturating increment for the statistics counters
// ---------------------------------------------------------------------------
package ext_trig_pkg;

   localparam int ST_IDLE    = 0;
   localparam int ST_QUALIFY = 1;
   localparam int ST_ACTIVE  = 2;
   localparam int ST_HOLDOFF = 3;
   localparam int NUM_ST     = 4;

   localparam int                CNT_W   = 16;
   localparam logic [CNT_W-1:0]  CNT_SAT = 16'hFFFF;

   typedef enum logic [NUM_ST-1:0] {
      IDLE    = NUM_ST'(1 << ST_IDLE),
      QUALIFY = NUM_ST'(1 << ST_QUALIFY),
      ACTIVE  = NUM_ST'(1 << ST_ACTIVE),
      HOLDOFF = NUM_ST'(1 << ST_HOLDOFF)
   } trig_state_e;

   // Statistics counters stick at full scale instead of wrapping.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == CNT_SAT) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/ext_trig_sync.sv
// ---------------------------------------------------------------------------
// ext_trig_sync
// Brings the asynchronous front-panel trigger into the ttc_clk domain through
// a SYNC_STAGES-deep flop chain and flags its rising edge.
//
// Ports:
//   ttc_clk    in   40 MHz TTC clock
//   reset40_n  in   asynchronous active-low reset (chain and delay flop clear)
//   trig_in    in   raw trigger, asynchronous to ttc_clk
//   trig_s     out  synchronised trigger (last chain stage)
//   trig_s_d   out  trig_s delayed one cycle
//   rise       out  trig_s & ~trig_s_d
// ---------------------------------------------------------------------------
module ext_trig_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic ttc_clk,
   input  logic reset40_n,
   input  logic trig_in,
   output logic trig_s,
   output logic trig_s_d,
   output logic rise
);

   logic [SYNC_STAGES-1:0] sync_q;

   always_ff @(posedge ttc_clk or negedge reset40_n) begin
      if (!reset40_n) begin
         sync_q   <= '0;
         trig_s_d <= 1'b0;
      end else begin
         sync_q   <= {sync_q[SYNC_STAGES-2:0], trig_in};
         trig_s_d <= sync_q[SYNC_STAGES-1];
      end
   end

   assign trig_s = sync_q[SYNC_STAGES-1];
   assign rise   = trig_s & ~trig_s_d;

endmodule

// File: rtl/ext_trigger_conditioner.sv
// ---------------------------------------------------------------------------
// ext_trigger_conditioner
// Conditions the raw front-panel trigger: synchronises it into the TTC domain,
// rejects pulses shorter than FILTER_CYCLES synchronised samples, enforces a
// programmable dead time after each accepted trigger and keeps reject/glitch
// statistics.
//
// Parameters:
//   SYNC_STAGES    synchroniser depth (>= 2)
//   FILTER_CYCLES  consecutive high samples needed to accept (>= 1)
//   HOLDOFF_W      width of holdoff_cycles / holdoff counter
//
// Ports:
//   ttc_clk         in   40 MHz TTC clock
//   reset40_n       in   asynchronous active-low reset
//   trig_in         in   raw trigger, asynchronous
//   enable          in   allow new triggers to start
//   holdoff_cycles  in   dead time after release, in ttc_clk ticks
//   trig_level      out  conditioned level for the raw trigger counter
//   trig_pulse      out  one-cycle strobe per accepted trigger
//   busy            out  qualifying, active or in holdoff
//   rejected_count  out  rises seen during holdoff (saturating)
//   glitch_count    out  aborted qualifications (saturating)
//
// Optional build macro EXT_TRIG_TIMESTAMP_EN adds:
//   rst_trigger_timestamp in   clears the tick counter and trig_timestamp
//   trig_timestamp        out  tick of the first qualified sample
//   timestamp_valid       out  strobes with trig_pulse
// ---------------------------------------------------------------------------
module ext_trigger_conditioner
   import ext_trig_pkg::*;
#(
   parameter int SYNC_STAGES   = 2,
   parameter int FILTER_CYCLES = 3,
   parameter int HOLDOFF_W     = 16
) (
   input  logic                 ttc_clk,
   input  logic                 reset40_n,
   input  logic                 trig_in,
   input  logic                 enable,
   input  logic [HOLDOFF_W-1:0] holdoff_cycles,
`ifdef EXT_TRIG_TIMESTAMP_EN
   input  logic                 rst_trigger_timestamp,
   output logic [31:0]          trig_timestamp,
   output logic                 timestamp_valid,
`endif
   output logic                 trig_level,
   output logic                 trig_pulse,
   output logic                 busy,
   output logic [CNT_W-1:0]     rejected_count,
   output logic [CNT_W-1:0]     glitch_count
);

   localparam int FILT_W = $clog2(FILTER_CYCLES + 1);

   logic trig_s, trig_s_d, rise;

   ext_trig_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .ttc_clk   (ttc_clk),
      .reset40_n (reset40_n),
      .trig_in   (trig_in),
      .trig_s    (trig_s),
      .trig_s_d  (trig_s_d),
      .rise      (rise)
   );

   trig_state_e          state_q, state_d;
   logic [FILT_W-1:0]    filt_q, filt_d;
   logic [HOLDOFF_W-1:0] hold_q, hold_d;
   logic                 level_q, level_d;
   logic                 pulse_q, pulse_d;
   logic [CNT_W-1:0]     rej_q, rej_d;
   logic [CNT_W-1:0]     glitch_q, glitch_d;
   logic                 accept;

   // A new trigger starts only on an edge; a level already high when the
   // block becomes idle or enabled never starts one.
   assign accept = (state_q == IDLE) && rise && enable;

   always_ff @(posedge ttc_clk or negedge reset40_n) begin
      if (!reset40_n) begin
         state_q  <= IDLE;
         filt_q   <= '0;
         hold_q   <= '0;
         level_q  <= 1'b0;
         pulse_q  <= 1'b0;
         rej_q    <= '0;
         glitch_q <= '0;
      end else begin
         state_q  <= state_d;
         filt_q   <= filt_d;
         hold_q   <= hold_d;
         level_q  <= level_d;
         pulse_q  <= pulse_d;
         rej_q    <= rej_d;
         glitch_q <= glitch_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      filt_d   = filt_q;
      hold_d   = hold_q;
      level_d  = 1'b0;
      pulse_d  = 1'b0;
      rej_d    = rej_q;
      glitch_d = glitch_q;
      unique case (state_q)
         IDLE: begin
            if (accept) begin
               filt_d = FILT_W'(1);
               if (FILTER_CYCLES == 1) begin
                  state_d = ACTIVE;
                  level_d = 1'b1;
                  pulse_d = 1'b1;
               end else begin
                  state_d = QUALIFY;
               end
            end
         end
         QUALIFY: begin
            if (!trig_s) begin
               state_d  = IDLE;
               glitch_d = sat_inc(glitch_q);
            end else if (filt_q == FILT_W'(FILTER_CYCLES - 1)) begin
               state_d = ACTIVE;
               filt_d  = filt_q + 1'b1;
               level_d = 1'b1;
               pulse_d = 1'b1;
            end else begin
               filt_d = filt_q + 1'b1;
            end
         end
         ACTIVE: begin
            // level falls the cycle after trig_s falls
            if (trig_s) begin
               level_d = 1'b1;
            end else if (holdoff_cycles == '0) begin
               state_d = IDLE;
            end else begin
               state_d = HOLDOFF;
               hold_d  = holdoff_cycles;
            end
         end
         HOLDOFF: begin
            if (rise) rej_d = sat_inc(rej_q);
            // hold_q is loaded non-zero, so the count ends on 1
            if (hold_q == HOLDOFF_W'(1)) state_d = IDLE;
            hold_d = hold_q - 1'b1;
         end
         default: state_d = IDLE;
      endcase
   end

   assign trig_level     = level_q;
   assign trig_pulse     = pulse_q;
   assign busy           = (state_q != IDLE);
   assign rejected_count = rej_q;
   assign glitch_count   = glitch_q;

`ifdef EXT_TRIG_TIMESTAMP_EN
   logic [31:0] tick_q;
   logic [31:0] cap_q;

   // cap_q holds the tick of the first high sample while qualifying; with a
   // single-sample filter the trigger is accepted in that same cycle and the
   // live tick is used directly.
   always_ff @(posedge ttc_clk or negedge reset40_n) begin
      if (!reset40_n) begin
         tick_q          <= '0;
         cap_q           <= '0;
         trig_timestamp  <= '0;
         timestamp_valid <= 1'b0;
      end else begin
         tick_q          <= rst_trigger_timestamp ? 32'd0 : tick_q + 32'd1;
         timestamp_valid <= pulse_d;
         if (accept) cap_q <= tick_q;
         if (rst_trigger_timestamp)
            trig_timestamp <= '0;
         else if (pulse_d)
            trig_timestamp <= (state_q == IDLE) ? tick_q : cap_q;
      end
   end
`endif

endmodule

// File: tb/tb_ext_trigger_conditioner.sv
// ---------------------------------------------------------------------------
// tb_ext_trigger_conditioner
// Self-checking bench for ext_trigger_conditioner (SYNC_STAGES=2,
// FILTER_CYCLES=3). Directed scenarios followed by random trigger bursts,
// every cycle compared with a reference model that tracks triggers by
// absolute cycle numbers (start cycle of a qualification, end cycle of the
// dead time). Build with EXT_TRIG_TIMESTAMP_EN to include the timestamp check.
// ---------------------------------------------------------------------------
module tb_ext_trigger_conditioner;

   localparam int SYNC = 2;
   localparam int F    = 3;
   localparam int HW   = 16;

   logic          ttc_clk = 1'b0;
   logic          reset40_n = 1'b0;
   logic          trig_in = 1'b0;
   logic          enable = 1'b0;
   logic [HW-1:0] holdoff_cycles = '0;
   logic          trig_level, trig_pulse, busy;
   logic [15:0]   rejected_count, glitch_count;
`ifdef EXT_TRIG_TIMESTAMP_EN
   logic          rst_trigger_timestamp = 1'b0;
   logic [31:0]   trig_timestamp;
   logic          timestamp_valid;
`endif

   always #5 ttc_clk = ~ttc_clk;

   ext_trigger_conditioner #(
      .SYNC_STAGES(SYNC), .FILTER_CYCLES(F), .HOLDOFF_W(HW)
   ) dut (
      .ttc_clk               (ttc_clk),
      .reset40_n             (reset40_n),
      .trig_in               (trig_in),
      .enable                (enable),
      .holdoff_cycles        (holdoff_cycles),
`ifdef EXT_TRIG_TIMESTAMP_EN
      .rst_trigger_timestamp (rst_trigger_timestamp),
      .trig_timestamp        (trig_timestamp),
      .timestamp_valid       (timestamp_valid),
`endif
      .trig_level            (trig_level),
      .trig_pulse            (trig_pulse),
      .busy                  (busy),
      .rejected_count        (rejected_count),
      .glitch_count          (glitch_count)
   );

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   longint cyc      = 0;    // index of the current cycle
   bit     hist[0:SYNC];    // trig_in sampled at the last SYNC+1 edges, newest first
   longint run_start;       // cycle of the accepted edge while qualifying, -1 otherwise
   bit     m_act;
   bit     m_pulse;
   longint hold_end;        // first cycle after the dead time
   int     m_rej, m_glitch;
   int     n_pulse, n_level;
   longint pulse_cyc;

   task automatic model_reset();
      for (int i = 0; i <= SYNC; i++) hist[i] = 1'b0;
      run_start = -1;
      m_act     = 1'b0;
      m_pulse   = 1'b0;
      hold_end  = cyc;
      m_rej     = 0;
      m_glitch  = 0;
   endtask

   // Advance the model across one rising edge; inputs still hold the values
   // of the cycle that just ended.
   task automatic model_edge();
      bit ts1, ts2, rs, idle;
      cyc++;
      ts1  = hist[SYNC-1];          // synchronised level in the ended cycle
      ts2  = hist[SYNC];            // and one cycle earlier
      rs   = ts1 & ~ts2;
      m_pulse = 1'b0;
      idle = (run_start < 0) && !m_act && (cyc - 1 >= hold_end);
      if (!idle && run_start < 0 && !m_act && rs && m_rej < 65535) m_rej++;
      if (idle && rs && enable) run_start = cyc - 1;
      if (run_start >= 0) begin
         if (!ts1) begin
            if (m_glitch < 65535) m_glitch++;
            run_start = -1;
         end else if (cyc - run_start >= F) begin
            m_act     = 1'b1;
            m_pulse   = 1'b1;
            run_start = -1;
         end
      end else if (m_act && !ts1) begin
         m_act    = 1'b0;
         hold_end = cyc + longint'(holdoff_cycles);
      end
      for (int i = SYNC; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = trig_in;
   endtask

   task automatic check_out();
      bit exp_busy;
      exp_busy = (run_start >= 0) || m_act || (cyc < hold_end);
      chk("trig_level", trig_level, m_act);
      chk("trig_pulse", trig_pulse, m_pulse);
      chk("busy", busy, exp_busy);
      chk("rejected_count", rejected_count, m_rej);
      chk("glitch_count", glitch_count, m_glitch);
      if (trig_pulse) begin
         n_pulse++;
         pulse_cyc = cyc;
      end
      if (trig_level) n_level++;
   endtask

   // One clock cycle: drive inputs at the falling edge, check at the next one.
   task automatic step(input bit tin, input bit en, input logic [HW-1:0] ho);
      trig_in        = tin;
      enable         = en;
      holdoff_cycles = ho;
      @(posedge ttc_clk);
      model_edge();
      @(negedge ttc_clk);
      check_out();
   endtask

   task automatic idle_for(input int n);
      repeat (n) step(1'b0, 1'b1, '0);
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_level"},  trig_level, 0);
      chk({tag, "_pulse"},  trig_pulse, 0);
      chk({tag, "_busy"},   busy, 0);
      chk({tag, "_rej"},    rejected_count, 0);
      chk({tag, "_glitch"}, glitch_count, 0);
   endtask

   initial begin
      longint t0;
      int     hi, lo, ho_max;
      bit     en, got;

      // reset state
      repeat (3) @(negedge ttc_clk);
      check_zero("reset");
      model_reset();
      reset40_n = 1'b1;
      idle_for(4);

      // 1: 10-cycle trigger, no dead time
      n_pulse = 0; n_level = 0;
      t0 = cyc;
      repeat (10) step(1'b1, 1'b1, 16'd0);
      idle_for(10);
      chk("t1_pulses", n_pulse, 1);
      chk("t1_latency", 32'(pulse_cyc - t0), SYNC + F);
      chk("t1_level_cycles", n_level, 8);
      chk("t1_rej", rejected_count, 0);
      chk("t1_glitch", glitch_count, 0);

      // 2: short glitch
      n_pulse = 0;
      repeat (2) step(1'b1, 1'b1, 16'd0);
      idle_for(8);
      chk("t2_pulses", n_pulse, 0);
      chk("t2_glitch", glitch_count, 1);
      chk("t2_busy", busy, 0);

      // 3: second pulse falls inside the dead time, third is after it
      n_pulse = 0;
      repeat (6) step(1'b1, 1'b1, 16'd20);
      repeat (4) step(1'b0, 1'b1, 16'd20);
      repeat (6) step(1'b1, 1'b1, 16'd20);
      repeat (30) step(1'b0, 1'b1, 16'd20);
      chk("t3_pulses_a", n_pulse, 1);
      chk("t3_rej", rejected_count, 1);
      repeat (6) step(1'b1, 1'b1, 16'd20);
      repeat (30) step(1'b0, 1'b1, 16'd20);
      chk("t3_pulses_b", n_pulse, 2);

      // 4: level already high when enable rises
      n_pulse = 0;
      repeat (5) step(1'b1, 1'b0, 16'd0);
      repeat (10) step(1'b1, 1'b1, 16'd0);
      chk("t4_no_pulse", n_pulse, 0);
      idle_for(3);
      repeat (6) step(1'b1, 1'b1, 16'd0);
      idle_for(5);
      chk("t4_pulse", n_pulse, 1);

      // 5: rejected_count saturation
      force dut.rej_q = 16'hFFFE;
      m_rej = 65534;
      idle_for(1);
      release dut.rej_q;
      idle_for(1);
      repeat (5) step(1'b1, 1'b1, 16'd40);
      repeat (3) step(1'b0, 1'b1, 16'd40);
      repeat (3) begin
         repeat (2) step(1'b1, 1'b1, 16'd40);
         repeat (2) step(1'b0, 1'b1, 16'd40);
      end
      chk("t5_sat", rejected_count, 16'hFFFF);
      idle_for(45);
      chk("t5_hold", rejected_count, 16'hFFFF);

      // 6: asynchronous reset while ACTIVE
      repeat (6) step(1'b1, 1'b1, 16'd0);
      chk("t6_active", trig_level, 1);
      #2 reset40_n = 1'b0;
      #1 check_zero("t6_async");
      model_reset();
      @(negedge ttc_clk);
      reset40_n = 1'b1;
      repeat (6) step(1'b1, 1'b1, 16'd0);
      idle_for(8);

`ifdef EXT_TRIG_TIMESTAMP_EN
      rst_trigger_timestamp = 1'b1;
      idle_for(1);                     // tick is 0 in the next cycle
      rst_trigger_timestamp = 1'b0;
      idle_for(100 - SYNC);            // trig_s first high at tick 100
      got = 1'b0;
      for (int i = 0; i < 10; i++) begin
         step(1'b1, 1'b1, 16'd0);
         if (trig_pulse && !got) begin
            got = 1'b1;
            chk("ts_value", trig_timestamp, 100);
            chk("ts_valid", timestamp_valid, 1);
         end
      end
      chk("ts_seen", got, 1);
      idle_for(8);
`endif

      // random bursts, glitches, enable toggles, changing dead time
      for (int b = 0; b < 160; b++) begin
         hi     = $urandom_range(1, 8);
         lo     = $urandom_range(1, 14);
         en     = ($urandom_range(0, 3) != 0);
         ho_max = ($urandom_range(0, 1) != 0) ? 6 : 0;
         repeat (hi) step(1'b1, en ^ ($urandom_range(0, 9) == 0), HW'($urandom_range(0, ho_max)));
         repeat (lo) step(1'b0, en ^ ($urandom_range(0, 9) == 0), HW'($urandom_range(0, ho_max)));
      end
      idle_for(10);

      $display("[TB] %0d tests run, %0d failed", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/ext_trigger_conditioner.md
Name: ext_trigger_conditioner

Overview:
Conditions the raw asynchronous front-panel trigger before it reaches the front-panel trigger counter and trigger processing.
- Synchronises the input into the 40 MHz TTC domain.
- Rejects glitches shorter than a programmable width.
- Applies a programmable holdoff (dead time) after each accepted trigger.
- Produces a clean level for the raw counter, a one-cycle pulse for processing, and reject/glitch statistics.

Parameters:
SYNC_STAGES, 2, number of synchroniser flops on trig_in (min 2)
FILTER_CYCLES, 3, consecutive high synchronised samples needed to qualify a trigger (min 1)
HOLDOFF_W, 16, width of holdoff_cycles and the holdoff counter

Ports:
ttc_clk  in  1  40 MHz TTC clock; the only clock
reset40_n  in  1  asynchronous active-low reset
trig_in  in  1  raw front-panel trigger, asynchronous to ttc_clk
enable  in  1  accept new triggers when high
holdoff_cycles  in  HOLDOFF_W  dead time after trigger release, in 25 ns ticks; sampled on entry to HOLDOFF
trig_level  out  1  conditioned trigger level; feeds the raw trigger counter's ext_trigger
trig_pulse  out  1  single-cycle strobe per accepted trigger
busy  out  1  high in QUALIFY, ACTIVE or HOLDOFF
rejected_count  out  16  rising edges seen during HOLDOFF; saturates at 0xFFFF
glitch_count  out  16  qualifications aborted by early low; saturates at 0xFFFF

Behaviour:
- Reset (reset40_n low, asynchronous):
  - Synchroniser flops and trig_s_d = 0.
  - state = IDLE.
  - All outputs = 0; both counts = 0.
- Synchronisation:
  - trig_s = last stage of the SYNC_STAGES chain.
  - trig_s_d = trig_s delayed one cycle.
  - rise = trig_s & ~trig_s_d.
- State encoding: one-hot, states IDLE, QUALIFY, ACTIVE, HOLDOFF.
- IDLE:
  - On rise & enable: filt_cnt = 1.
  - If FILTER_CYCLES == 1, go to ACTIVE; otherwise go to QUALIFY.
  - A level held high (no rise) never triggers.
- QUALIFY:
  - trig_s high: filt_cnt++. When the count reaches FILTER_CYCLES, go to ACTIVE.
  - trig_s low: go to IDLE and increment glitch_count.
- Output timing on qualification: with trig_s high in cycles k..k+F-1 (F = FILTER_CYCLES), the following hold in cycle k+F:
  - trig_pulse = 1 (that cycle only);
  - trig_level = 1;
  - state = ACTIVE.
- Total latency from the first sampled trig_in high to trig_pulse is SYNC_STAGES+F cycles.
- ACTIVE:
  - trig_level stays 1 while trig_s is high.
  - On trig_s low: trig_level = 0 next cycle.
  - Then go to IDLE if holdoff_cycles == 0; otherwise load hold_cnt = holdoff_cycles and go to HOLDOFF.
- HOLDOFF:
  - hold_cnt decrements each cycle. Go to IDLE in the cycle after hold_cnt == 1, so the block spends exactly holdoff_cycles cycles in HOLDOFF.
  - Each rise in HOLDOFF increments rejected_count.
  - A trigger still high on exit is not accepted; a new rise is required.
- enable low:
  - Blocks only the IDLE to QUALIFY/ACTIVE transition.
  - A trigger in progress completes normally.
  - A rise in IDLE with enable low is ignored and not counted.
- Saturation: both counts hold at 0xFFFF and never wrap.
- Edge cases:
  - Simultaneous abort and count: single increment only.
  - holdoff_cycles changing mid-HOLDOFF has no effect.

Optional Feature:
EXT_TRIG_TIMESTAMP_EN
- Defined: adds input rst_trigger_timestamp (1, TTC Channel B) and outputs trig_timestamp (32) and timestamp_valid (1).
  - A free-running 32-bit tick counter clears on reset or rst_trigger_timestamp, then wraps modulo 2^32.
  - trig_timestamp latches the counter value of cycle k (first qualified sample), presented with trig_pulse.
  - timestamp_valid pulses with trig_pulse.
  - rst_trigger_timestamp also clears trig_timestamp.
- Undefined: these ports and the counter are absent.

Decomposition:
- Shared package (ext_trig_pkg): one-hot state indices (IDLE=0, QUALIFY=1, ACTIVE=2, HOLDOFF=3), counter width constant 16, saturation value 16'hFFFF.
- One sub-module: ext_trig_sync, a parameterised SYNC_STAGES flop chain with asynchronous active-low reset, plus the rise detector.

Test Plan:
- Each scenario uses SYNC_STAGES=2, FILTER_CYCLES=3, enable=1.
1. trig_in high 10 cycles, holdoff_cycles=0 -> one trig_pulse, 5 cycles after the first sampled high. trig_level high for 8 cycles. rejected_count=0, glitch_count=0.
2. trig_in high 2 cycles -> no trig_pulse, glitch_count=1, busy returns low.
3. Two 6-cycle pulses 4 cycles apart with holdoff_cycles=20 -> one trig_pulse, rejected_count=1. A third pulse after holdoff expires -> second trig_pulse.
4. trig_in held high across enable 0->1 -> no pulse until trig_in falls and rises again.
5. Force rejected_count to 0xFFFE, then two rejected rises -> rejected_count=0xFFFF, held.
6. reset40_n pulsed low mid-ACTIVE (async, between edges) -> outputs 0 immediately and state IDLE. With EXT_TRIG_TIMESTAMP_EN and rst_trigger_timestamp at cycle 0, a trigger first sampled at cycle 100 -> trig_timestamp=100.
